hazard_ctrl: RTL and testbench

Pipeline hazard and redirect controller for the 5-stage MIPS core. It keeps a shadow pipeline of destination-register information for E/M/W. From that state it produces the stall, PC-redirect and forwarding selects that drive the datapath muxes: PC-select, D-stage comparator forward, and E-stage ALU operand forward. It also holds a busy counter for the multi-cycle multiply/divide unit, so that HI/LO users stall until the result is ready.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, PC-redirect and forwarding control for the 5-stage
// MIPS pipeline, built on a shadow pipeline of E/M/W destination info.
// Ports: clk, rst_n (async, active-low); D-stage operand/dest/use flags
// (d_*); mul/div start (e_md_start, e_md_div); outputs stall, flush_pc,
// fwd_rs_d/fwd_rt_d (0 regfile, 1 M), fwd_rs_e/fwd_rt_e (0 ID/EX, 1 M,
// 2 W), md_busy.
// Optional feature: define HAZARD_MD_STALL_EN to build the mul/div busy
// counter and its HI/LO stall term; otherwise md_busy is tied low.
module hazard_ctrl #(
    parameter logic [3:0] MULT_CYCLES = 4'd5,
    parameter logic [3:0] DIV_CYCLES  = 4'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_use_rs_d,
    input  logic       d_use_rt_d,
    input  logic       d_use_rs_e,
    input  logic       d_use_rt_e,
    input  logic       d_wr_en,
    input  logic [4:0] d_wr_addr,
    input  logic       d_is_load,
    input  logic       d_md_use,
    input  logic       d_redirect,
    input  logic       e_md_start,
    input  logic       e_md_div,
    output logic       stall,
    output logic       flush_pc,
    output logic       fwd_rs_d,
    output logic       fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);

    // W only feeds forwarding, so it carries no load flag.
    logic       r_e_wr, r_e_load, r_m_wr, r_m_load, r_w_wr;
    logic [4:0] r_e_addr, r_e_rs, r_e_rt, r_m_addr, r_w_addr;

    logic w_e_hit_rs, w_e_hit_rt, w_m_hit_rs, w_m_hit_rt;
    logic w_m_hit_ers, w_m_hit_ert, w_w_hit_ers, w_w_hit_ert;
    logic w_stall_d, w_stall_e, w_md_stall, w_md_busy, w_stall;

    function automatic logic f_hit(input logic wr, input logic [4:0] a,
                                   input logic [4:0] r);
        return wr && (a == r) && (r != 5'd0);
    endfunction

    assign w_e_hit_rs  = f_hit(r_e_wr, r_e_addr, d_rs);
    assign w_e_hit_rt  = f_hit(r_e_wr, r_e_addr, d_rt);
    assign w_m_hit_rs  = f_hit(r_m_wr, r_m_addr, d_rs);
    assign w_m_hit_rt  = f_hit(r_m_wr, r_m_addr, d_rt);
    assign w_m_hit_ers = f_hit(r_m_wr, r_m_addr, r_e_rs);
    assign w_m_hit_ert = f_hit(r_m_wr, r_m_addr, r_e_rt);
    assign w_w_hit_ers = f_hit(r_w_wr, r_w_addr, r_e_rs);
    assign w_w_hit_ert = f_hit(r_w_wr, r_w_addr, r_e_rt);

    // D-stage consumers wait for anything in E, and for a load still in M.
    assign w_stall_d = (d_use_rs_d & (w_e_hit_rs | (r_m_load & w_m_hit_rs)))
                     | (d_use_rt_d & (w_e_hit_rt | (r_m_load & w_m_hit_rt)));
    // E-stage consumers only wait for a load sitting in E.
    assign w_stall_e = r_e_load & ((d_use_rs_e & w_e_hit_rs)
                                 | (d_use_rt_e & w_e_hit_rt));

`ifdef HAZARD_MD_STALL_EN
    logic [3:0] r_md_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= 4'd0;
        end else if (e_md_start && (r_md_cnt == 4'd0)) begin
            r_md_cnt <= e_md_div ? DIV_CYCLES : MULT_CYCLES;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    assign w_md_busy  = (r_md_cnt != 4'd0);
    assign w_md_stall = d_md_use & (w_md_busy | e_md_start);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            a_md_start_busy: assert (!(e_md_start && w_md_busy));
        end
    end
`endif
`else
    logic w_unused_md;
    assign w_unused_md = &{1'b0, d_md_use, e_md_start, e_md_div};
    assign w_md_busy   = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

    assign w_stall = w_stall_d | w_stall_e | w_md_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_wr   <= 1'b0;
            r_e_addr <= 5'd0;
            r_e_load <= 1'b0;
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_m_wr   <= 1'b0;
            r_m_addr <= 5'd0;
            r_m_load <= 1'b0;
            r_w_wr   <= 1'b0;
            r_w_addr <= 5'd0;
        end else begin
            r_w_wr   <= r_m_wr;
            r_w_addr <= r_m_addr;
            r_m_wr   <= r_e_wr;
            r_m_addr <= r_e_addr;
            r_m_load <= r_e_load;
            if (w_stall) begin
                r_e_wr   <= 1'b0;
                r_e_addr <= 5'd0;
                r_e_load <= 1'b0;
                r_e_rs   <= 5'd0;
                r_e_rt   <= 5'd0;
            end else begin
                r_e_wr   <= d_wr_en;
                r_e_addr <= d_wr_addr;
                r_e_load <= d_is_load;
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
            end
        end
    end

    // Outputs are held low for the whole reset window, including inputs
    // that would otherwise reach them combinationally.
    always_comb begin
        stall    = rst_n & w_stall;
        flush_pc = rst_n & d_redirect & ~w_stall;
        fwd_rs_d = rst_n & w_m_hit_rs;
        fwd_rt_d = rst_n & w_m_hit_rt;
        md_busy  = rst_n & w_md_busy;
        fwd_rs_e = 2'd0;
        fwd_rt_e = 2'd0;
        if (rst_n) begin
            if (w_m_hit_ers)      fwd_rs_e = 2'd1;
            else if (w_w_hit_ers) fwd_rs_e = 2'd2;
            if (w_m_hit_ert)      fwd_rt_e = 2'd1;
            else if (w_w_hit_ert) fwd_rt_e = 2'd2;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table of pipeline cycles for hazard_ctrl plus
// hand sequences for mul/div busy, reset during busy and reset outputs.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] d_rs = 5'd0, d_rt = 5'd0, d_wr_addr = 5'd0;
    logic       d_use_rs_d = 1'b0, d_use_rt_d = 1'b0;
    logic       d_use_rs_e = 1'b0, d_use_rt_e = 1'b0;
    logic       d_wr_en = 1'b0, d_is_load = 1'b0, d_md_use = 1'b0;
    logic       d_redirect = 1'b0, e_md_start = 1'b0, e_md_div = 1'b0;
    logic       stall, flush_pc, fwd_rs_d, fwd_rt_d, md_busy;
    logic [1:0] fwd_rs_e, fwd_rt_e;

    int checks = 0;
    int failures = 0;

`ifdef HAZARD_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    hazard_ctrl #(.MULT_CYCLES(4'd5), .DIV_CYCLES(4'd10)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs_d(d_use_rs_d), .d_use_rt_d(d_use_rt_d),
        .d_use_rs_e(d_use_rs_e), .d_use_rt_e(d_use_rt_e),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_is_load(d_is_load),
        .d_md_use(d_md_use), .d_redirect(d_redirect),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .stall(stall), .flush_pc(flush_pc),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urd, utd, ure, ute, wr;
        logic [4:0] wa;
        logic       ld, redir;
        logic       x_st, x_fl, x_frd, x_ftd;
        logic [1:0] x_fre, x_fte;
        string      nm;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    function automatic vec_t mk(string nm, int rs, int rt, int urd, int utd,
                                int ure, int ute, int wr, int wa, int ld,
                                int rd, int st, int fl, int frd, int ftd,
                                int fre, int fte);
        vec_t v;
        v.nm = nm;
        v.rs = 5'(rs);   v.rt = 5'(rt);
        v.urd = 1'(urd); v.utd = 1'(utd);
        v.ure = 1'(ure); v.ute = 1'(ute);
        v.wr = 1'(wr);   v.wa = 5'(wa);
        v.ld = 1'(ld);   v.redir = 1'(rd);
        v.x_st = 1'(st); v.x_fl = 1'(fl);
        v.x_frd = 1'(frd); v.x_ftd = 1'(ftd);
        v.x_fre = 2'(fre); v.x_fte = 2'(fte);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        d_rs = v.rs; d_rt = v.rt;
        d_use_rs_d = v.urd; d_use_rt_d = v.utd;
        d_use_rs_e = v.ure; d_use_rt_e = v.ute;
        d_wr_en = v.wr; d_wr_addr = v.wa;
        d_is_load = v.ld; d_redirect = v.redir;
    endtask

    task automatic chk_all0(input string nm);
        chk({nm, ".stall"}, int'(stall), 0);
        chk({nm, ".flush"}, int'(flush_pc), 0);
        chk({nm, ".frd"}, int'(fwd_rs_d), 0);
        chk({nm, ".ftd"}, int'(fwd_rt_d), 0);
        chk({nm, ".fre"}, int'(fwd_rs_e), 0);
        chk({nm, ".fte"}, int'(fwd_rt_e), 0);
        chk({nm, ".busy"}, int'(md_busy), 0);
    endtask

    // Starts a mul/div with a HI/LO user waiting in D; counts busy and
    // stall cycles from the start cycle on.
    task automatic run_md(input string nm, input bit div, input int n);
        int nb, ns;
        nb = 0; ns = 0;
        d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = div;
        #4;
        chk({nm, ".busy0"}, int'(md_busy), 0);
        if (stall) ns++;
        @(posedge clk); #1;
        e_md_start = 1'b0; e_md_div = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #4;
            if (md_busy) nb++;
            if (stall) ns++;
            @(posedge clk); #1;
        end
        chk({nm, ".busy_cycles"}, nb, MD_EN ? n : 0);
        chk({nm, ".stall_cycles"}, ns, MD_EN ? n + 1 : 0);
        d_md_use = 1'b0;
    endtask

    initial begin
        vec_t z, a3;
        z  = mk("z", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        a3 = mk("a3", 3, 3, 0, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk("add3",    1, 2, 0,0,1,1, 1, 3, 0,0, 0,0,0,0,0,0);
        tbl[1]  = mk("beq_st",  3, 4, 1,1,0,0, 0, 0, 0,1, 1,0,0,0,0,0);
        tbl[2]  = mk("beq_fwd", 3, 4, 1,1,0,0, 0, 0, 0,1, 0,1,1,0,0,0);
        tbl[3]  = mk("lw5",     1, 0, 0,0,1,0, 1, 5, 1,0, 0,0,0,0,2,0);
        tbl[4]  = mk("lu_st",   5, 1, 0,0,1,1, 1, 6, 0,0, 1,0,0,0,0,0);
        tbl[5]  = mk("lu_go",   5, 1, 0,0,1,1, 1, 6, 0,0, 0,0,1,0,0,0);
        tbl[6]  = mk("lu_fwdw", 1, 2, 0,0,1,1, 1, 7, 0,0, 0,0,0,0,2,0);
        tbl[7]  = mk("add7",    1, 2, 0,0,1,1, 1, 7, 0,0, 0,0,0,0,0,0);
        tbl[8]  = mk("or8",     7, 6, 0,0,1,1, 1, 8, 0,0, 0,0,1,0,0,0);
        tbl[9]  = mk("m_prio",  0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0,0,1,0);
        tbl[10] = mk("add0a",   1, 2, 0,0,1,1, 1, 0, 0,0, 0,0,0,0,0,0);
        tbl[11] = mk("add0b",   1, 2, 0,0,1,1, 1, 0, 0,0, 0,0,0,0,0,0);
        tbl[12] = mk("beq00",   0, 0, 1,1,0,0, 0, 0, 0,1, 0,1,0,0,0,0);
        tbl[13] = mk("lw9",     1, 0, 0,0,1,0, 1, 9, 1,0, 0,0,0,0,0,0);
        tbl[14] = mk("ld_d1",   9, 0, 1,1,0,0, 0, 0, 0,1, 1,0,0,0,0,0);
        tbl[15] = mk("ld_d2",   9, 0, 1,1,0,0, 0, 0, 0,1, 1,0,1,0,0,0);
        tbl[16] = mk("ld_go",   9, 0, 1,1,0,0, 0, 0, 0,1, 0,1,0,0,0,0);
        tbl[17] = mk("nop17",   0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0,0,0,0);
        tbl[18] = mk("add10",   1, 2, 0,0,1,1, 1,10, 0,0, 0,0,0,0,0,0);
        tbl[19] = mk("nop19",   0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0,0,0,0);
        tbl[20] = mk("xor11",   1,10, 0,1,1,1, 1,11, 0,0, 0,0,0,1,0,0);
        tbl[21] = mk("w_rt",    0, 0, 0,0,0,0, 0, 0, 0,0, 0,0,0,0,0,2);

        // Reset with inputs that would otherwise drive outputs high.
        #1 rst_n = 1'b0;
        drive(mk("r", 3, 3, 1, 1, 1, 1, 1, 3, 1, 1, 0,0,0,0,0,0));
        d_md_use = 1'b1; e_md_start = 1'b1;
        #6;
        chk_all0("in_reset");
        @(negedge clk);
        drive(z); d_md_use = 1'b0; e_md_start = 1'b0;
        rst_n = 1'b1;
        #1;
        chk_all0("release");
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #4;
            chk({tbl[i].nm, ".stall"}, int'(stall), int'(tbl[i].x_st));
            chk({tbl[i].nm, ".flush"}, int'(flush_pc), int'(tbl[i].x_fl));
            chk({tbl[i].nm, ".frd"}, int'(fwd_rs_d), int'(tbl[i].x_frd));
            chk({tbl[i].nm, ".ftd"}, int'(fwd_rt_d), int'(tbl[i].x_ftd));
            chk({tbl[i].nm, ".fre"}, int'(fwd_rs_e), int'(tbl[i].x_fre));
            chk({tbl[i].nm, ".fte"}, int'(fwd_rt_e), int'(tbl[i].x_fte));
            @(posedge clk); #1;
        end
        drive(z);

        run_md("div", 1'b1, 10);
        run_md("mult", 1'b0, 5);

        // Reset while a div is 6 cycles from done, with M/E forwarding live.
        drive(a3); e_md_start = 1'b1; e_md_div = 1'b1;
        @(posedge clk); #1;
        e_md_start = 1'b0; e_md_div = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        d_md_use = 1'b1;
        #4;
        chk("pre_rst.busy", int'(md_busy), MD_EN ? 1 : 0);
        chk("pre_rst.stall", int'(stall), MD_EN ? 1 : 0);
        chk("pre_rst.fre", int'(fwd_rs_e), 1);
        chk("pre_rst.frd", int'(fwd_rs_d), 1);
        rst_n = 1'b0;
        #1;
        chk_all0("mid_rst");
        @(negedge clk);
        drive(z); d_md_use = 1'b0;
        d_rs = 5'd3; d_rt = 5'd3;
        rst_n = 1'b1;
        #1;
        chk_all0("rel2");
        @(posedge clk); #1;
        chk_all0("rel2_edge");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
